way_lookup_ctrl: RTL and testbench

// - Sequences one cache lookup at a time: reads the tag array, samples the per-way
//   hit/valid vectors, encodes the hit to a way index and, on a miss, picks the

---
 rtl/cache_pkg.sv | 57 +++++
 rtl/onehot_encoder.sv | 22 ++
 rtl/way_lookup_ctrl.sv | 149 ++++++++++++++
 tb/tb_way_lookup_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and tree-PLRU helpers for the way lookup controller.
package cache_pkg;

  localparam int CACHE_WAYS     = 8;
  localparam int CACHE_SETS     = 64;
  localparam int CACHE_TAG_BITS = 12;
  localparam int CACHE_WAY_W    = $clog2(CACHE_WAYS);
  localparam int CACHE_SET_W    = $clog2(CACHE_SETS);

  typedef logic [CACHE_WAY_W-1:0]  way_idx_t;
  typedef logic [CACHE_SET_W-1:0]  set_idx_t;
  typedef logic [CACHE_WAYS-2:0]   plru_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOOKUP  = 2'd1,
    COMPARE = 2'd2,
    RESP    = 2'd3
  } state_t;

  // Walk from the root: a 0 bit steers left, a 1 bit steers right.
  function automatic way_idx_t plru_victim(input plru_t bits);
    int       node;
    way_idx_t way;
    node = 0;
    way  = {CACHE_WAY_W{1'b0}};
    for (int lvl = 0; lvl < CACHE_WAY_W; lvl++) begin
      way[CACHE_WAY_W-1-lvl] = bits[node];
      node = 2 * node + 1 + int'(bits[node]);
    end
    return way;
  endfunction

  function automatic plru_t plru_update(input plru_t bits, input way_idx_t way);
    int    node;
    plru_t nbits;
    logic  dir;
    node  = 0;
    nbits = bits;
    for (int lvl = 0; lvl < CACHE_WAY_W; lvl++) begin
      dir         = way[CACHE_WAY_W-1-lvl];
      nbits[node] = ~dir;
      node        = 2 * node + 1 + int'(dir);
    end
    return nbits;
  endfunction

  function automatic way_idx_t first_zero(input logic [CACHE_WAYS-1:0] vec);
    way_idx_t way;
    way = {CACHE_WAY_W{1'b0}};
    for (int i = CACHE_WAYS - 1; i >= 0; i--) begin
      way = vec[i] ? way : way_idx_t'(i);
    end
    return way;
  endfunction

endpackage

// File: rtl/onehot_encoder.sv
// Encodes a hit vector to the lowest set index and flags more than one set bit.
module onehot_encoder #(
  parameter int WAYS = 8
) (
  input  logic [WAYS-1:0]         vec_i,
  output logic [$clog2(WAYS)-1:0] idx_o,
  output logic                    multi_o
);

  localparam int            IDX_W = $clog2(WAYS);
  localparam logic [WAYS-1:0] ONE = {{(WAYS-1){1'b0}}, 1'b1};

  // Scan downward so the lowest set bit is the last one written.
  always_comb begin
    idx_o = {IDX_W{1'b0}};
    for (int i = WAYS - 1; i >= 0; i--) begin
      idx_o = vec_i[i] ? IDX_W'(i) : idx_o;
    end
    multi_o = |(vec_i & (vec_i - ONE));
  end

endmodule

// File: rtl/way_lookup_ctrl.sv
// Single-outstanding cache lookup sequencer with per-set tree pseudo-LRU
// replacement state.
module way_lookup_ctrl
  import cache_pkg::*;
#(
  parameter int WAYS     = CACHE_WAYS,
  parameter int SETS     = CACHE_SETS,
  parameter int TAG_BITS = CACHE_TAG_BITS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [$clog2(SETS)-1:0] req_set,
  input  logic [TAG_BITS-1:0]     req_tag,
  output logic                    tag_rd_en,
  output logic [$clog2(SETS)-1:0] tag_rd_set,
  output logic [TAG_BITS-1:0]     tag_cmp_tag,
  input  logic [WAYS-1:0]         hit_vec,
  input  logic [WAYS-1:0]         valid_vec,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic                    resp_hit,
  output logic [$clog2(WAYS)-1:0] resp_way,
  output logic                    resp_err
);

  localparam int WAY_W = $clog2(WAYS);
  localparam int SET_W = $clog2(SETS);

  state_t              state_q, state_d;
  logic [SET_W-1:0]    set_q, set_d;
  logic [TAG_BITS-1:0] tag_q, tag_d;
  logic                resp_hit_q, resp_hit_d;
  logic [WAY_W-1:0]    resp_way_q, resp_way_d;
  logic                resp_err_q, resp_err_d;
  logic                req_ready_q, tag_rd_en_q, resp_valid_q;
  plru_t               plru_q [SETS];
  plru_t               plru_cur_s, plru_wr_s;
  logic                plru_we_s;
  logic [WAY_W-1:0]    hit_idx_s, miss_way_s;
  logic                multi_s, hit_any_s;

  onehot_encoder #(.WAYS(WAYS)) u_hit_enc (
    .vec_i   (hit_vec),
    .idx_o   (hit_idx_s),
    .multi_o (multi_s)
  );

  assign plru_cur_s = plru_q[set_q];
  assign hit_any_s  = |hit_vec;
  // Prefer filling an invalid line over evicting a live one.
  assign miss_way_s = (&valid_vec) ? plru_victim(plru_cur_s) : first_zero(valid_vec);

  // Next-state, response capture and PLRU write decision.
  always_comb begin
    state_d    = state_q;
    set_d      = set_q;
    tag_d      = tag_q;
    resp_hit_d = resp_hit_q;
    resp_way_d = resp_way_q;
    resp_err_d = resp_err_q;
    plru_we_s  = 1'b0;
    plru_wr_s  = plru_cur_s;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = LOOKUP;
          set_d   = req_set;
          tag_d   = req_tag;
        end else begin
          state_d = IDLE;
        end
      end
      LOOKUP: state_d = COMPARE;
      COMPARE: begin
        state_d = RESP;
        if (multi_s) begin
          resp_hit_d = 1'b1;
          resp_err_d = 1'b1;
          resp_way_d = hit_idx_s;
        end else if (hit_any_s) begin
          resp_hit_d = 1'b1;
          resp_err_d = 1'b0;
          resp_way_d = hit_idx_s;
          plru_we_s  = 1'b1;
          plru_wr_s  = plru_update(plru_cur_s, hit_idx_s);
        end else begin
          resp_hit_d = 1'b0;
          resp_err_d = 1'b0;
          resp_way_d = miss_way_s;
          plru_we_s  = 1'b1;
          plru_wr_s  = plru_update(plru_cur_s, miss_way_s);
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, latches, registered strobes and PLRU storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      set_q        <= {SET_W{1'b0}};
      tag_q        <= {TAG_BITS{1'b0}};
      resp_hit_q   <= 1'b0;
      resp_way_q   <= {WAY_W{1'b0}};
      resp_err_q   <= 1'b0;
      req_ready_q  <= 1'b1;
      tag_rd_en_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        plru_q[s] <= {(WAYS-1){1'b0}};
      end
    end else begin
      state_q      <= state_d;
      set_q        <= set_d;
      tag_q        <= tag_d;
      resp_hit_q   <= resp_hit_d;
      resp_way_q   <= resp_way_d;
      resp_err_q   <= resp_err_d;
      req_ready_q  <= (state_d == IDLE);
      tag_rd_en_q  <= (state_d == LOOKUP);
      resp_valid_q <= (state_d == RESP);
      if (plru_we_s) begin
        plru_q[set_q] <= plru_wr_s;
      end else begin
        plru_q[set_q] <= plru_cur_s;
      end
    end
  end

  assign req_ready   = req_ready_q;
  assign tag_rd_en   = tag_rd_en_q;
  assign tag_rd_set  = set_q;
  assign tag_cmp_tag = tag_q;
  assign resp_valid  = resp_valid_q;
  assign resp_hit    = resp_hit_q;
  assign resp_way    = resp_way_q;
  assign resp_err    = resp_err_q;

endmodule

// File: tb/tb_way_lookup_ctrl.sv
// Randomised scoreboard bench for way_lookup_ctrl with a tree-PLRU reference model.
module tb_way_lookup_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_set;
  logic [11:0] req_tag;
  logic        tag_rd_en;
  logic [5:0]  tag_rd_set;
  logic [11:0] tag_cmp_tag;
  logic [7:0]  hit_vec;
  logic [7:0]  valid_vec;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_hit;
  logic [2:0]  resp_way;
  logic        resp_err;

  way_lookup_ctrl #(.WAYS(8), .SETS(64), .TAG_BITS(12)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_set     (req_set),
    .req_tag     (req_tag),
    .tag_rd_en   (tag_rd_en),
    .tag_rd_set  (tag_rd_set),
    .tag_cmp_tag (tag_cmp_tag),
    .hit_vec     (hit_vec),
    .valid_vec   (valid_vec),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_hit    (resp_hit),
    .resp_way    (resp_way),
    .resp_err    (resp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       hit;
    logic [2:0] way;
    logic       err;
    int         cyc;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   hold_len = 0;
  int   hold_tok = 0;
  bit [6:0] mtree [64];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference PLRU: heap level l starts at node 2^l-1, offset by the way prefix.
  function automatic logic [2:0] m_victim(input bit [6:0] t);
    int way;
    int node;
    way  = 0;
    node = 0;
    for (int l = 0; l < 3; l++) begin
      way  = way * 2 + int'(t[node]);
      node = (1 << (l + 1)) - 1 + way;
    end
    return way[2:0];
  endfunction

  function automatic bit [6:0] m_touch(input bit [6:0] t, input int w);
    bit [6:0] r;
    r = t;
    for (int l = 0; l < 3; l++) begin
      r[(1 << l) - 1 + (w >> (3 - l))] = (((w >> (2 - l)) & 1) == 0);
    end
    return r;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Consumer: long stalls on request, otherwise random backpressure.
  initial begin
    int tok_seen;
    int remaining;
    tok_seen   = 0;
    remaining  = 0;
    resp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (hold_tok != tok_seen && resp_valid) begin
        tok_seen  = hold_tok;
        remaining = hold_len;
      end
      if (remaining > 0) begin
        resp_ready = 1'b0;
        remaining--;
      end else if (hold_tok != tok_seen) begin
        resp_ready = 1'b0;
      end else begin
        resp_ready = ($urandom_range(0, 2) != 0);
      end
    end
  end

  // Monitor: pops the scoreboard on each new response and checks stability.
  initial begin
    exp_t       cur;
    logic       in_resp;
    logic       hs_pending;
    logic [2:0] snap_way;
    logic       snap_hit;
    logic       snap_err;
    in_resp    = 1'b0;
    hs_pending = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_resp    = 1'b0;
        hs_pending = 1'b0;
      end else begin
        if (hs_pending) begin
          check("ready_after_hs", 32'(req_ready), 32'd1);
          check("valid_after_hs", 32'(resp_valid), 32'd0);
          hs_pending = 1'b0;
        end
        if (resp_valid) begin
          if (!in_resp) begin
            if (sb_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_resp: got response way %0d with no request pending", resp_way);
            end else begin
              cur = sb_q.pop_front();
              check("resp_hit", 32'(resp_hit), 32'(cur.hit));
              check("resp_way", 32'(resp_way), 32'(cur.way));
              check("resp_err", 32'(resp_err), 32'(cur.err));
              check("latency", 32'(cyc - cur.cyc), 32'd3);
            end
            in_resp  = 1'b1;
            snap_way = resp_way;
            snap_hit = resp_hit;
            snap_err = resp_err;
          end else begin
            check("hold_way", 32'(resp_way), 32'(snap_way));
            check("hold_hit", 32'(resp_hit), 32'(snap_hit));
            check("hold_err", 32'(resp_err), 32'(snap_err));
          end
          check("req_ready_busy", 32'(req_ready), 32'd0);
          if (resp_ready) begin
            in_resp    = 1'b0;
            hs_pending = 1'b1;
          end
        end
      end
    end
  end

  task automatic issue(input logic [5:0] set, input logic [11:0] tag,
                       input logic [7:0] hv, input logic [7:0] vv, input bit do_rst);
    int   t;
    int   pc;
    exp_t e;
    @(negedge clk);
    req_valid = 1'b1;
    req_set   = set;
    req_tag   = tag;
    t = 0;
    while (!req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: req_ready stayed 0 for %0d cycles", t);
      req_valid = 1'b0;
      return;
    end
    if (!do_rst) begin
      pc    = $countones(hv);
      e.cyc = cyc;
      e.way = 3'd0;
      for (int i = 7; i >= 0; i--) begin
        if (pc > 0 && hv[i]) e.way = 3'(i);
        if (pc == 0 && !vv[i]) e.way = 3'(i);
      end
      e.hit = (pc > 0);
      e.err = (pc > 1);
      if (pc == 0 && vv == 8'hFF) e.way = m_victim(mtree[set]);
      if (pc <= 1) mtree[set] = m_touch(mtree[set], int'(e.way));
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_set   = 6'($urandom);
    req_tag   = 12'($urandom);
    @(negedge clk);
    check("tag_rd_en", 32'(tag_rd_en), 32'd1);
    check("tag_rd_set", 32'(tag_rd_set), 32'(set));
    check("tag_cmp_tag", 32'(tag_cmp_tag), 32'(tag));
    @(posedge clk);
    #1;
    hit_vec   = hv;
    valid_vec = vv;
    if (do_rst) rst = 1'b1;
    @(posedge clk);
    #1;
    hit_vec   = 8'($urandom);
    valid_vec = 8'($urandom);
    if (do_rst) begin
      rst = 1'b0;
      for (int s = 0; s < 64; s++) mtree[s] = 7'd0;
      @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_tag_rd_en", 32'(tag_rd_en), 32'd0);
      check("rst_resp_way", 32'(resp_way), 32'd0);
    end
  endtask

  initial begin
    logic [7:0] hv;
    logic [7:0] vv;
    int         a;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_set   = 6'd0;
    req_tag   = 12'd0;
    hit_vec   = 8'hA5;
    valid_vec = 8'h5A;
    for (int s = 0; s < 64; s++) mtree[s] = 7'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_req_ready", 32'(req_ready), 32'd1);
    check("reset_tag_rd_en", 32'(tag_rd_en), 32'd0);
    check("reset_resp_valid", 32'(resp_valid), 32'd0);
    check("reset_resp_hit", 32'(resp_hit), 32'd0);
    check("reset_resp_way", 32'(resp_way), 32'd0);
    check("reset_resp_err", 32'(resp_err), 32'd0);

    issue(6'd5, 12'h123, 8'h00, 8'h00, 1'b0);
    issue(6'd3, 12'h456, 8'h00, 8'hFF, 1'b0);
    issue(6'd3, 12'h456, 8'h00, 8'hFF, 1'b0);
    issue(6'd3, 12'h789, 8'h20, 8'hFF, 1'b0);
    issue(6'd3, 12'h78A, 8'h00, 8'hFF, 1'b0);
    issue(6'd3, 12'hABC, 8'h24, 8'hFF, 1'b0);
    issue(6'd3, 12'hABD, 8'h00, 8'hFF, 1'b0);
    hold_len = 4;
    hold_tok++;
    issue(6'd7, 12'h0F0, 8'h04, 8'hFF, 1'b0);
    issue(6'd7, 12'h0F1, 8'h00, 8'h7F, 1'b0);
    issue(6'd3, 12'hDEF, 8'h00, 8'hFF, 1'b0);
    issue(6'd3, 12'hDEE, 8'h00, 8'hFF, 1'b1);
    issue(6'd3, 12'hDED, 8'h00, 8'hFF, 1'b0);

    for (int n = 0; n < 60; n++) begin
      a  = $urandom_range(0, 7);
      vv = 8'($urandom);
      case ($urandom_range(0, 3))
        0: hv = 8'd1 << a;
        1: begin hv = 8'd0; vv = 8'hFF; end
        2: hv = 8'd0;
        default: hv = (8'd1 << a) | (8'd1 << ((a + 1 + $urandom_range(0, 6)) % 8));
      endcase
      if ($urandom_range(0, 5) == 0) begin
        hold_len = $urandom_range(1, 4);
        hold_tok++;
      end
      issue(6'($urandom_range(0, 3)), 12'($urandom), hv, vv, 1'b0);
    end

    a = 0;
    while (sb_q.size() != 0 && a < 200) begin
      @(negedge clk);
      a++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d responses still outstanding", sb_q.size());
    end
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
